// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port scheduler: default widths and the
// burst-read state encoding.
package sram_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 128;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BURST = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the external loader and the systolic
// writeback path. The grant is combinational from the requests and the pointer.
module rr_arb2 (
  input  logic clk,
  input  logic rstn,
  input  logic req_ext,
  input  logic req_sys,
  output logic gnt_ext,
  output logic gnt_sys
);

  // ptr_sys names the requester that wins a tie (0 = ext, 1 = sys). It always
  // points away from the most recent winner, so a tie alternates.
  logic ptr_sys;

  always_comb begin
    gnt_ext = req_ext && (!req_sys || !ptr_sys);
    gnt_sys = req_sys && (!req_ext ||  ptr_sys);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_sys <= 1'b0;
    end else if (gnt_ext) begin
      ptr_sys <= 1'b1;
    end else if (gnt_sys) begin
      ptr_sys <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_port_sched.sv
// SRAM port scheduler: arbitrates two write requesters onto the single SRAM
// write port and runs address bursts on read port a.
module sram_port_sched
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ext_wvalid,
  output logic                  ext_wready,
  input  logic [ADDR_WIDTH-1:0] ext_waddr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  input  logic                  sys_wvalid,
  output logic                  sys_wready,
  input  logic [ADDR_WIDTH-1:0] sys_waddr,
  input  logic [DATA_WIDTH-1:0] sys_wdata,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] rd_len,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sram_write,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic [ADDR_WIDTH-1:0] sram_raddr_a,
  input  logic [DATA_WIDTH-1:0] sram_dout_a,
  output logic [1:0]            rd_state
);

  // Handshake: a write transfers on a cycle where valid && ready are both high.
  // ready is computed from the current valids, so a requester must hold valid
  // and its address/data stable until it sees ready; it lands in the SRAM on
  // the following cycle.
  logic gnt_ext;
  logic gnt_sys;
  logic w_accept;

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req_ext (ext_wvalid),
    .req_sys (sys_wvalid),
    .gnt_ext (gnt_ext),
    .gnt_sys (gnt_sys)
  );

  assign ext_wready = gnt_ext;
  assign sys_wready = gnt_sys;
  assign w_accept   = gnt_ext || gnt_sys;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sram_write <= 1'b0;
      sram_waddr <= '0;
      sram_din   <= '0;
    end else begin
      sram_write <= w_accept;
      if (gnt_ext) begin
        sram_waddr <= ext_waddr;
        sram_din   <= ext_wdata;
      end else if (gnt_sys) begin
        sram_waddr <= sys_waddr;
        sram_din   <= sys_wdata;
      end
    end
  end

  // Burst read FSM. rd_cnt holds the number of addresses still to issue after
  // the one currently on sram_raddr_a.
  rd_state_e             state;
  rd_state_e             state_nxt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  start_burst;
  logic                  start_empty;
  logic                  last_issue;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_burst = 1'b0;
    start_empty = 1'b0;
    last_issue  = 1'b0;
    case (state)
      RD_IDLE: begin
        if (rd_start && (rd_len != '0)) begin
          start_burst = 1'b1;
          state_nxt   = RD_BURST;
        end else if (rd_start) begin
          start_empty = 1'b1;
        end
      end
      RD_BURST: begin
        if (rd_cnt == '0) begin
          last_issue = 1'b1;
          state_nxt  = RD_DRAIN;
        end
      end
      RD_DRAIN: state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sram_raddr_a <= '0;
      rd_cnt       <= '0;
      rd_valid     <= 1'b0;
      rd_done      <= 1'b0;
    end else begin
      // SRAM data for the address issued in BURST arrives one cycle later.
      rd_valid <= (state == RD_BURST);
      rd_done  <= last_issue || start_empty;
      if (start_burst) begin
        sram_raddr_a <= rd_base;
        rd_cnt       <= rd_len - ADDR_WIDTH'(1);
      end else if ((state == RD_BURST) && (rd_cnt != '0)) begin
        sram_raddr_a <= sram_raddr_a + ADDR_WIDTH'(1);
        rd_cnt       <= rd_cnt - ADDR_WIDTH'(1);
      end
    end
  end

  assign rd_busy  = (state != RD_IDLE);
  assign rd_data  = sram_dout_a;
  assign rd_state = state;

endmodule

// File: doc/sram_port_sched.md
SRAM_PORT_SCHED -- requirements
Module: sram_port_sched

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning SRAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 128, meaning SRAM word width (8-bit x 16 lanes).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports ext_wvalid/ext_wready  input/output  1/1  external loader write handshake.
REQ-006 The block SHALL have ports ext_waddr/ext_wdata  input  ADDR_WIDTH/DATA_WIDTH  external write address and data.
REQ-007 The block SHALL have ports sys_wvalid/sys_wready  input/output  1/1  systolic writeback handshake.
REQ-008 The block SHALL have ports sys_waddr/sys_wdata  input  ADDR_WIDTH/DATA_WIDTH  systolic write address and data.
REQ-009 The block SHALL have ports rd_start/rd_base/rd_len  input  1/ADDR_WIDTH/ADDR_WIDTH  burst-read request on port a.
REQ-010 The block SHALL have ports rd_busy/rd_valid/rd_done  output  1/1/1  burst status, data-valid strobe, completion pulse.
REQ-011 The block SHALL have port rd_data  output  DATA_WIDTH  burst read word (equals sram_dout_a).
REQ-012 The block SHALL have ports sram_write/sram_waddr/sram_din  output  1/ADDR_WIDTH/DATA_WIDTH  SRAM write port.
REQ-013 The block SHALL have ports sram_raddr_a/sram_dout_a  output/input  ADDR_WIDTH/DATA_WIDTH  SRAM read port a (1-cycle read latency).

Function
REQ-014 Write grant SHALL be combinational: one requester ready per cycle; a single valid requester always granted.
REQ-015 When both valid, grant SHALL go to the requester not granted in the most recent accepted transfer (round-robin); ext has priority after reset.
REQ-016 An accepted transfer (valid&&ready) SHALL drive sram_write=1 with its captured address and data in the next cycle only (1-cycle registered latency).
REQ-017 With no accepted transfer, sram_write SHALL be 0 next cycle; sram_waddr/sram_din hold their last values.
REQ-018 Read FSM states SHALL be IDLE, BURST, DRAIN; rd_busy=1 in BURST and DRAIN.
REQ-019 IDLE: rd_start with rd_len!=0 SHALL capture rd_base/rd_len and enter BURST; rd_start with rd_len==0 SHALL pulse rd_done next cycle, no rd_valid, stay IDLE.
REQ-020 BURST: sram_raddr_a SHALL be base+k for k=0..len-1, one per cycle, modulo 2^ADDR_WIDTH (wrap 0xFFF->0x000).
REQ-021 After the issue k=len-1, FSM SHALL enter DRAIN for one cycle, then IDLE.
REQ-022 rd_valid SHALL assert exactly one cycle after each issued address; rd_done SHALL pulse coincident with the last rd_valid.
REQ-023 rd_start while rd_busy=1 SHALL be ignored.
REQ-024 Writes and burst reads SHALL proceed concurrently; no read-after-write forwarding is provided.
REQ-025 In IDLE sram_raddr_a SHALL hold its last value.

Reset
REQ-026 On rstn=0, asynchronously: sram_write=0, sram_waddr=0, sram_din=0, sram_raddr_a=0, rd_valid=0, rd_done=0, FSM=IDLE, round-robin pointer=ext.
REQ-027 Reset mid-burst SHALL abort the burst with no rd_done; mid-write the pending sram_write SHALL be dropped.

Structure
REQ-028 Read FSM state encoding and default widths SHALL live in shared package sram_pkg.
REQ-029 The write arbiter SHALL be a sub-module rr_arb2 (2-way round-robin, grant plus last-grant pointer); read FSM stays in the top.

Verification
REQ-030 ext only, addr 0x000..0x03F, 64 words -> 64 sram_write pulses, addresses in order, 1-cycle latency.
REQ-031 ext and sys valid every cycle for 8 cycles -> grants alternate ext,sys,ext,...; 4 writes each.
REQ-032 rd_base=0x010, rd_len=4 -> sram_raddr_a 0x010..0x013, rd_valid 4 cycles, rd_done with 4th, then rd_busy=0.
REQ-033 rd_base=0xFFE, rd_len=3 -> addresses 0xFFE,0xFFF,0x000; second rd_start mid-burst ignored.
REQ-034 rd_len=0 -> single rd_done pulse, no rd_valid, rd_busy stays 0.
REQ-035 rstn low during burst cycle 2 -> rd_valid=0, rd_busy=0, no rd_done; next burst after release completes normally.
